// File: rtl/tmcuart_phy.sv
// Half-duplex single-wire 8N1 byte transceiver below the TMC UART engine.
// Optional build macro: TMCUART_PHY_MAJORITY_EN (2-of-3 majority at each RX sample point).
module tmcuart_phy #(
  parameter int BIT_CLKS = 48,
  parameter int CNT_BITS = $clog2(BIT_CLKS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dir_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err,
  output logic       rx_busy,
  input  logic       line_in,
  output logic       line_out,
  output logic       line_oe
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [CNT_BITS-1:0] CNT_ZERO  = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] BIT_LAST  = CNT_BITS'(BIT_CLKS - 1);
  // STOP state is one cycle short: the final stop cycle is spent in IDLE so a
  // new byte can be accepted there without an idle gap on the wire.
  localparam logic [CNT_BITS-1:0] STOP_LAST = CNT_BITS'(BIT_CLKS - 2);
`ifdef TMCUART_PHY_MAJORITY_EN
  localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(BIT_CLKS / 2);
`else
  localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(BIT_CLKS / 2 - 1);
`endif

`ifdef TMCUART_PHY_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  tx_state_t           tx_state_r, tx_state_s;
  logic [CNT_BITS-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]          tx_bit_r, tx_bit_s;
  logic [7:0]          tx_shift_r, tx_shift_s;
  logic                line_out_r, line_out_s;
  logic                tx_busy_r, tx_busy_s;
  logic                line_oe_r, line_oe_s;

  rx_state_t           rx_state_r, rx_state_s;
  logic [CNT_BITS-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]          rx_bit_r, rx_bit_s;
  logic [7:0]          rx_shift_r, rx_shift_s;
  logic [7:0]          rx_byte_r, rx_byte_s;
  logic                rx_valid_r, rx_valid_s;
  logic                rx_err_r, rx_err_s;
  logic                rx_busy_r, rx_busy_s;
  logic                sync1_r, sync2_r, rx_prev_r;
  logic [1:0]          flush_r, flush_s;
  logic                rx_block_s, rx_fall_s, rx_sample_s;
`ifdef TMCUART_PHY_MAJORITY_EN
  logic                rx_prev2_r;
`endif

  // TX next-state and datapath
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    line_out_s = line_out_r;
    tx_busy_s  = tx_busy_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_s = TX_START;
          tx_cnt_s   = BIT_LAST;
          tx_shift_s = tx_byte;
          line_out_s = 1'b0;
          tx_busy_s  = 1'b1;
        end else begin
          line_out_s = 1'b1;
          tx_busy_s  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_r == CNT_ZERO) begin
          tx_state_s = TX_DATA;
          tx_cnt_s   = BIT_LAST;
          tx_bit_s   = 3'd0;
          line_out_s = tx_shift_r[0];
          tx_shift_s = {1'b1, tx_shift_r[7:1]};
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == CNT_ZERO) begin
          if (tx_bit_r == 3'd7) begin
            tx_state_s = TX_STOP;
            tx_cnt_s   = STOP_LAST;
            line_out_s = 1'b1;
          end else begin
            tx_bit_s   = tx_bit_r + 3'd1;
            tx_cnt_s   = BIT_LAST;
            line_out_s = tx_shift_r[0];
            tx_shift_s = {1'b1, tx_shift_r[7:1]};
          end
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == CNT_ZERO) begin
          tx_state_s = TX_IDLE;
        end else begin
          tx_cnt_s = tx_cnt_r - CNT_ONE;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        line_out_s = 1'b1;
        tx_busy_s  = 1'b0;
      end
    endcase
    line_oe_s = dir_tx | tx_busy_s;
  end

  // RX sampling, echo suppression and next-state
  always_comb begin
    flush_s    = line_oe_r ? 2'd2 : ((flush_r != 2'd0) ? flush_r - 2'd1 : 2'd0);
    rx_block_s = line_oe_r | (flush_r != 2'd0);
    rx_fall_s  = rx_prev_r & ~sync2_r;
`ifdef TMCUART_PHY_MAJORITY_EN
    rx_sample_s = maj3(rx_prev2_r, rx_prev_r, sync2_r);
`else
    rx_sample_s = sync2_r;
`endif
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_byte_s  = rx_byte_r;
    rx_valid_s = 1'b0;
    rx_err_s   = 1'b0;
    if (rx_block_s) begin
      rx_state_s = RX_IDLE;
    end else begin
      case (rx_state_r)
        RX_IDLE: begin
          if (rx_fall_s) begin
            rx_state_s = RX_START;
            rx_cnt_s   = HALF_LOAD;
          end else begin
            rx_state_s = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt_r == CNT_ZERO) begin
            if (rx_sample_s) begin
              rx_state_s = RX_IDLE;
            end else begin
              rx_state_s = RX_DATA;
              rx_cnt_s   = BIT_LAST;
              rx_bit_s   = 3'd0;
            end
          end else begin
            rx_cnt_s = rx_cnt_r - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == CNT_ZERO) begin
            rx_shift_s = {rx_sample_s, rx_shift_r[7:1]};
            rx_cnt_s   = BIT_LAST;
            if (rx_bit_r == 3'd7) begin
              rx_state_s = RX_STOP;
            end else begin
              rx_bit_s = rx_bit_r + 3'd1;
            end
          end else begin
            rx_cnt_s = rx_cnt_r - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == CNT_ZERO) begin
            rx_state_s = RX_IDLE;
            if (rx_sample_s) begin
              rx_byte_s  = rx_shift_r;
              rx_valid_s = 1'b1;
            end else begin
              rx_err_s = 1'b1;
            end
          end else begin
            rx_cnt_s = rx_cnt_r - CNT_ONE;
          end
        end
        default: rx_state_s = RX_IDLE;
      endcase
    end
    rx_busy_s = (rx_state_s != RX_IDLE);
  end

  // TX state and wire-drive registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      line_out_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      line_oe_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      line_out_r <= line_out_s;
      tx_busy_r  <= tx_busy_s;
      line_oe_r  <= line_oe_s;
    end
  end

  // RX synchroniser, history and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      rx_prev_r  <= 1'b1;
`ifdef TMCUART_PHY_MAJORITY_EN
      rx_prev2_r <= 1'b1;
`endif
      flush_r    <= 2'd0;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      sync1_r    <= line_in;
      sync2_r    <= sync1_r;
      rx_prev_r  <= sync2_r;
`ifdef TMCUART_PHY_MAJORITY_EN
      rx_prev2_r <= rx_prev_r;
`endif
      flush_r    <= flush_s;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_byte_r  <= rx_byte_s;
      rx_valid_r <= rx_valid_s;
      rx_err_r   <= rx_err_s;
      rx_busy_r  <= rx_busy_s;
    end
  end

  assign tx_busy  = tx_busy_r;
  assign line_out = line_out_r;
  assign line_oe  = line_oe_r;
  assign rx_valid = rx_valid_r;
  assign rx_err   = rx_err_r;
  assign rx_byte  = rx_byte_r;
  assign rx_busy  = rx_busy_r;

endmodule

// File: tb/tb_tmcuart_phy.sv
// Directed testbench for tmcuart_phy (BIT_CLKS = 48): TX framing, back-to-back,
// RX, framing error, echo/glitch rejection and mid-frame reset.
module tb_tmcuart_phy;

  logic       clk;
  logic       rst_n;
  logic       dir_tx;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       rx_busy;
  logic       line_in;
  logic       line_out;
  logic       line_oe;

  int n_vec;
  int n_err;

  logic lo_rec [0:1023];
  logic bz_rec [0:1023];
  logic oe_rec [0:1023];

  tmcuart_phy #(.BIT_CLKS(48)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dir_tx   (dir_tx),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_busy  (tx_busy),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy),
    .line_in  (line_in),
    .line_out (line_out),
    .line_oe  (line_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one 10-bit frame (LSB = start bit) on line_in, 48 cycles per bit, and watch RX.
  task automatic rx_run(input logic [9:0] fr, output int nv, output int ne,
                        output int vcyc, output int nb);
    nv = 0; ne = 0; vcyc = -1; nb = 0;
    for (int k = 0; k < 600; k++) begin
      line_in = (k < 480) ? fr[k / 48] : 1'b1;
      if (rx_valid === 1'b1) begin
        nv++;
        if (vcyc < 0) vcyc = k;
      end
      if (rx_err === 1'b1) ne++;
      if (rx_busy === 1'b1) nb++;
      tick();
    end
  endtask

  initial begin
    logic [9:0] fr;
    int cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; dir_tx = 1'b0; tx_start = 1'b0; tx_byte = 8'h00; line_in = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_line_out", {31'd0, line_out}, 32'd1);
    chk("rst_line_oe",  {31'd0, line_oe},  32'd0);
    chk("rst_tx_busy",  {31'd0, tx_busy},  32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_err",   {31'd0, rx_err},   32'd0);
    chk("rst_rx_busy",  {31'd0, rx_busy},  32'd0);
    chk("rst_rx_byte",  {24'd0, rx_byte},  32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single TX frame of 8'hA5
    dir_tx = 1'b1;
    repeat (3) tick();
    tx_byte = 8'hA5; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int k = 1; k <= 490; k++) begin
      lo_rec[k] = line_out; bz_rec[k] = tx_busy; oe_rec[k] = line_oe;
      tick();
    end
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d_first", i), {31'd0, lo_rec[i*48+1]},  {31'd0, fr[i]});
      chk($sformatf("a5_bit%0d_last", i),  {31'd0, lo_rec[i*48+48]}, {31'd0, fr[i]});
    end
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 490; k++) begin
      if (bz_rec[k] === 1'b1) cnt_a++;
      if (k <= 480 && oe_rec[k] !== 1'b1) cnt_b++;
    end
    chk("a5_busy_cycles", cnt_a, 32'd480);
    chk("a5_busy_end",    {31'd0, bz_rec[481]}, 32'd0);
    chk("a5_oe_low_cyc",  cnt_b, 32'd0);

    // Back-to-back: 8'h55 then 8'h05 in the first idle cycle; 8'hFF mid-frame is ignored
    tx_byte = 8'h55; tx_start = 1'b1;
    tick();
    for (int k = 1; k <= 970; k++) begin
      if (k == 200) begin
        tx_start = 1'b1; tx_byte = 8'hFF;
      end else if (k == 480) begin
        tx_start = 1'b1; tx_byte = 8'h05;
      end else begin
        tx_start = 1'b0;
      end
      lo_rec[k] = line_out; bz_rec[k] = tx_busy;
      tick();
    end
    tx_start = 1'b0;
    cnt_a = 0;
    for (int k = 1; k <= 970; k++) if (bz_rec[k] === 1'b1) cnt_a++;
    chk("b2b_busy_cycles", cnt_a, 32'd960);
    chk("b2b_busy_join",   {31'd0, bz_rec[481]}, 32'd1);
    chk("b2b_busy_end",    {31'd0, bz_rec[961]}, 32'd0);
    chk("b2b_ignore_mid",  {31'd0, lo_rec[300]}, 32'd0);
    chk("b2b_stop1",       {31'd0, lo_rec[480]}, 32'd1);
    fr = {1'b1, 8'h05, 1'b0};
    for (int i = 0; i < 10; i++)
      chk($sformatf("b2b_f2_bit%0d", i), {31'd0, lo_rec[480+i*48+24]}, {31'd0, fr[i]});

    dir_tx = 1'b0;
    repeat (10) tick();
    chk("oe_released", {31'd0, line_oe}, 32'd0);

    // RX of 8'h3C
    rx_run({1'b1, 8'h3C, 1'b0}, cnt_a, cnt_b, cnt_c, cnt_d);
    chk("rx3c_valid_cnt", cnt_a, 32'd1);
    chk("rx3c_err_cnt",   cnt_b, 32'd0);
    chk("rx3c_latency",   {31'd0, (cnt_c >= 457 && cnt_c <= 461)}, 32'd1);
    chk("rx3c_byte",      {24'd0, rx_byte}, 32'h3C);
    chk("rx3c_busy_seen", {31'd0, (cnt_d > 400)}, 32'd1);
    chk("rx3c_busy_end",  {31'd0, rx_busy}, 32'd0);

    // Framing error: 8'hC3 with a 0 stop bit
    rx_run({1'b0, 8'hC3, 1'b0}, cnt_a, cnt_b, cnt_c, cnt_d);
    chk("ferr_err_cnt",   cnt_b, 32'd1);
    chk("ferr_valid_cnt", cnt_a, 32'd0);
    chk("ferr_byte_held", {24'd0, rx_byte}, 32'h3C);

    // Self-echo: line low while the wire is driven
    dir_tx = 1'b1;
    repeat (3) tick();
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 120; k++) begin
      line_in = (k < 100) ? 1'b0 : 1'b1;
      if (k == 110) dir_tx = 1'b0;
      if (rx_busy === 1'b1) cnt_a++;
      if (rx_valid === 1'b1 || rx_err === 1'b1) cnt_b++;
      tick();
    end
    chk("echo_busy_cyc", cnt_a, 32'd0);
    chk("echo_pulses",   cnt_b, 32'd0);
    repeat (5) tick();

    // Glitch: 10-cycle low pulse
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 80; k++) begin
      line_in = (k < 10) ? 1'b0 : 1'b1;
      if (rx_busy === 1'b1) cnt_a++;
      if (rx_valid === 1'b1 || rx_err === 1'b1) cnt_b++;
      tick();
    end
    chk("glitch_busy_seen", {31'd0, (cnt_a > 0)}, 32'd1);
    chk("glitch_busy_end",  {31'd0, rx_busy}, 32'd0);
    chk("glitch_pulses",    cnt_b, 32'd0);

    // Reset at cycle 200 of a TX frame
    dir_tx = 1'b1;
    repeat (2) tick();
    tx_byte = 8'h00; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (199) tick();
    chk("pre_rst_line_out", {31'd0, line_out}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_line_out", {31'd0, line_out}, 32'd1);
    chk("mid_rst_line_oe",  {31'd0, line_oe},  32'd0);
    chk("mid_rst_tx_busy",  {31'd0, tx_busy},  32'd0);
    chk("mid_rst_rx_byte",  {24'd0, rx_byte},  32'd0);
    repeat (3) tick();
    dir_tx = 1'b0;
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; cnt_e = 0;
    for (int k = 0; k < 600; k++) begin
      if (tx_busy !== 1'b0) cnt_a++;
      if (line_out !== 1'b1) cnt_b++;
      if (line_oe !== 1'b0) cnt_c++;
      if (rx_valid !== 1'b0 || rx_err !== 1'b0) cnt_d++;
      if (rx_busy !== 1'b0) cnt_e++;
      tick();
    end
    chk("post_rst_tx_busy",  cnt_a, 32'd0);
    chk("post_rst_line_out", cnt_b, 32'd0);
    chk("post_rst_line_oe",  cnt_c, 32'd0);
    chk("post_rst_pulses",   cnt_d, 32'd0);
    chk("post_rst_rx_busy",  cnt_e, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
